ram_event_tracer: RTL and testbench

Parametrised RAM access tracer that turns the raw RAM bus signals into timestamped event packets and buffers them in a FIFO. It sits beside the system RAM port and is driven from the same signals the system interface exposes. A testbench or debug unit drains the packets through a valid/ready handshake. It adds access-type and address-window filtering, overflow accounting and duplicate suppression, none of which the plain signal bundle provides.

---
 rtl/ram_event_tracer_if.sv | 31 +++
 rtl/ram_event_tracer.sv | 123 ++++++++++++
 tb/tb_ram_event_tracer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_event_tracer_if.sv
// RAM bus snoop signals plus the event-packet valid/ready channel.
// The tracer uses the slave modport; the bench/debug side uses master.
interface ram_event_tracer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TS_W   = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ren;
  logic              ram_wen;
  logic [1:0]        ram_state;

  logic              evt_valid;
  logic              evt_ready;
  logic              evt_write;
  logic [ADDR_W-1:0] evt_addr;
  logic [DATA_W-1:0] evt_data;
  logic [TS_W-1:0]   evt_ts;

  modport master (
    output ram_addr, ram_store, ram_load, ram_ren, ram_wen, ram_state, evt_ready,
    input  evt_valid, evt_write, evt_addr, evt_data, evt_ts
  );

  modport slave (
    input  ram_addr, ram_store, ram_load, ram_ren, ram_wen, ram_state, evt_ready,
    output evt_valid, evt_write, evt_addr, evt_data, evt_ts
  );
endinterface

// File: rtl/ram_event_tracer.sv
// Snoops a RAM port, turns each completed access into a timestamped packet,
// filters by access type and address window, and buffers packets in a FIFO.
module ram_event_tracer #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TS_W          = 16,
  parameter int unsigned CNT_W         = 8,
  parameter logic [1:0]  CAPTURE_STATE = 2'd2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic [1:0]               cfg_mode,
  input  logic [ADDR_W-1:0]        cfg_addr_lo,
  input  logic [ADDR_W-1:0]        cfg_addr_hi,
  ram_event_tracer_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W + TS_W;

  logic [TS_W-1:0]  ts_d, ts_q;
  logic             armed_d, armed_q;
  logic [PtrW-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_d, rd_ptr_q;
  logic [PtrW:0]    count_d, count_q;
  logic             overflow_d, overflow_q;
  logic [CNT_W-1:0] drop_d, drop_q;

  logic [EntW-1:0]  mem [DEPTH];
  logic [EntW-1:0]  entry_in;
  logic [EntW-1:0]  head;

  logic hit, is_write, mode_ok, win_ok, accept;
  logic empty, full, pop, push, drop;

  // Qualify the bus cycle and apply the capture filters
  always_comb begin
    hit      = (bus.ram_state == CAPTURE_STATE) && (bus.ram_ren || bus.ram_wen);
    is_write = bus.ram_wen;
    mode_ok  = is_write ? cfg_mode[1] : cfg_mode[0];
    // An inverted window (lo > hi) can never satisfy both bounds
    win_ok   = (bus.ram_addr >= cfg_addr_lo) && (bus.ram_addr <= cfg_addr_hi);
    // armed_q limits capture to the first cycle of a contiguous hit run
    accept   = hit && armed_q && mode_ok && win_ok;
    entry_in = {is_write, bus.ram_addr, (is_write ? bus.ram_store : bus.ram_load), ts_q};
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push on full
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == (PtrW + 1)'(DEPTH));
    pop   = !empty && bus.evt_ready;
    push  = accept && (!full || pop);
    drop  = accept && full && !pop;

    ts_d       = ts_q + 1'b1;
    armed_d    = !hit;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      ts_q       <= '0;
      armed_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      armed_q    <= armed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Packet storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push && !clr && !RST) mem[wr_ptr_q] <= entry_in;
  end

  // Present the oldest entry, zero when empty
  always_comb begin
    head = empty ? '0 : mem[rd_ptr_q];
    {bus.evt_write, bus.evt_addr, bus.evt_data, bus.evt_ts} = head;
    bus.evt_valid = !empty;
    count         = count_q;
    overflow      = overflow_q;
    drop_cnt      = drop_q;
  end

endmodule

// File: tb/tb_ram_event_tracer.sv
module tb_ram_event_tracer;
  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_addr_lo;
  logic [31:0] cfg_addr_hi;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  logic [15:0] tb_ts;
  logic [15:0] exp_ts;
  int          errors = 0;
  int          checks = 0;

  ram_event_tracer_if #(.ADDR_W(32), .DATA_W(32), .TS_W(16)) bus ();

  ram_event_tracer dut (
    .CLK         (CLK),
    .RST         (RST),
    .clr         (clr),
    .cfg_mode    (cfg_mode),
    .cfg_addr_lo (cfg_addr_lo),
    .cfg_addr_hi (cfg_addr_hi),
    .bus         (bus.slave),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp: cycles since the last reset edge
  always @(posedge CLK) tb_ts <= RST ? 16'd0 : tb_ts + 16'd1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ram_state = 2'd0;
    bus.ram_ren   = 1'b0;
    bus.ram_wen   = 1'b0;
    tick();
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] st, input logic [31:0] ld);
    bus.ram_wen   = wr;
    bus.ram_ren   = rd;
    bus.ram_addr  = addr;
    bus.ram_store = st;
    bus.ram_load  = ld;
    bus.ram_state = 2'd2;
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] st, input logic [31:0] ld);
    drive(wr, rd, addr, st, ld);
    tick();
    idle();
  endtask

  task automatic pop();
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; clr = 1'b0; cfg_mode = 2'b00;
    cfg_addr_lo = '0; cfg_addr_hi = '0;
    bus.ram_addr = '0; bus.ram_store = '0; bus.ram_load = '0;
    bus.ram_ren = 1'b0; bus.ram_wen = 1'b0; bus.ram_state = 2'd0;
    bus.evt_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", bus.evt_valid, 1'b0);
    check_eq("rst_count", count, 5'd0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_drop", drop_cnt, 8'd0);
    check_eq("rst_addr", bus.evt_addr, 32'd0);
    RST = 1'b0;
    tick();

    // One write held for three capture cycles yields a single packet
    cfg_mode = 2'b11; cfg_addr_lo = 32'h0; cfg_addr_hi = 32'hFFFF_FFFF;
    exp_ts = tb_ts;
    drive(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0);
    tick();
    check_eq("wr_latency_valid", bus.evt_valid, 1'b1);
    tick();
    tick();
    idle();
    check_eq("wr_single_count", count, 5'd1);
    check_eq("wr_type", bus.evt_write, 1'b1);
    check_eq("wr_addr", bus.evt_addr, 32'h100);
    check_eq("wr_data", bus.evt_data, 32'hDEAD_BEEF);
    check_eq("wr_ts", bus.evt_ts, exp_ts);
    pop();
    check_eq("wr_popped", count, 5'd0);

    // Simultaneous ren/wen is a write carrying store data
    access(1'b1, 1'b1, 32'h200, 32'h11, 32'h22);
    check_eq("both_type", bus.evt_write, 1'b1);
    check_eq("both_data", bus.evt_data, 32'h11);
    pop();

    // Reads only, window 0x1000..0x1FFF
    cfg_mode = 2'b01; cfg_addr_lo = 32'h1000; cfg_addr_hi = 32'h1FFF;
    access(1'b1, 1'b0, 32'h1004, 32'hA, 32'h0);
    access(1'b0, 1'b1, 32'h0FFC, 32'h0, 32'hB);
    access(1'b0, 1'b1, 32'h1FFF, 32'h0, 32'hC);
    check_eq("filt_count", count, 5'd1);
    check_eq("filt_addr", bus.evt_addr, 32'h1FFF);
    check_eq("filt_type", bus.evt_write, 1'b0);
    check_eq("filt_data", bus.evt_data, 32'hC);
    check_eq("filt_drop", drop_cnt, 8'd0);
    pop();

    // Inverted window accepts nothing
    cfg_addr_lo = 32'h2000; cfg_addr_hi = 32'h1000;
    access(1'b0, 1'b1, 32'h1800, 32'h0, 32'h1);
    check_eq("inv_window_count", count, 5'd0);

    // Overflow: 20 reads into a 16-deep FIFO
    cfg_mode = 2'b11; cfg_addr_lo = 32'h0; cfg_addr_hi = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) access(1'b0, 1'b1, 32'h4000 + 32'(4 * i), 32'h0, 32'(i));
    check_eq("ovf_count", count, 5'd16);
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_drop", drop_cnt, 8'd4);
    check_eq("ovf_head", bus.evt_addr, 32'h4000);

    // Full FIFO with pop and push together
    bus.evt_ready = 1'b1;
    drive(1'b0, 1'b1, 32'h5000, 32'h0, 32'h55);
    tick();
    bus.evt_ready = 1'b0;
    idle();
    check_eq("fullpop_count", count, 5'd16);
    check_eq("fullpop_drop", drop_cnt, 8'd4);
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("drain_%0d", i), bus.evt_addr, 32'h4000 + 32'(4 * i));
      pop();
    end
    check_eq("drain_tail", bus.evt_addr, 32'h5000);
    pop();
    check_eq("drain_empty", count, 5'd0);

    // Drop counter saturation
    for (int i = 0; i < 316; i++) access(1'b0, 1'b1, 32'h6000 + 32'(i), 32'h0, 32'(i));
    check_eq("sat_drop", drop_cnt, 8'd255);
    check_eq("sat_count", count, 5'd16);

    // clr flushes but leaves the timestamp running
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_count", count, 5'd0);
    check_eq("clr_overflow", overflow, 1'b0);
    check_eq("clr_drop", drop_cnt, 8'd0);
    check_eq("clr_valid", bus.evt_valid, 1'b0);
    exp_ts = tb_ts;
    access(1'b0, 1'b1, 32'h7000, 32'h0, 32'h77);
    check_eq("clr_ts_kept", bus.evt_ts, exp_ts);
    check_eq("clr_post_data", bus.evt_data, 32'h77);

    // Reset in the middle of an overflowing burst
    for (int i = 0; i < 17; i++) access(1'b0, 1'b1, 32'h8000 + 32'(i), 32'h0, 32'(i));
    drive(1'b1, 1'b0, 32'h9000, 32'h99, 32'h0);
    RST = 1'b1;
    tick();
    check_eq("rst2_valid", bus.evt_valid, 1'b0);
    check_eq("rst2_count", count, 5'd0);
    check_eq("rst2_overflow", overflow, 1'b0);
    check_eq("rst2_drop", drop_cnt, 8'd0);
    check_eq("rst2_write", bus.evt_write, 1'b0);
    check_eq("rst2_data", bus.evt_data, 32'd0);
    check_eq("rst2_ts", bus.evt_ts, 16'd0);
    RST = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
